data_sram_like_resp: RTL and testbench

DATA_SRAM_LIKE_RESP -- requirements
Module: data_sram_like_resp

---
 rtl/data_sram_like_resp_if.sv | 32 +++
 rtl/data_sram_like_resp.sv | 120 ++++++++++++
 tb/tb_data_sram_like_resp.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_like_resp_if.sv
// Bundle of the SRAM-like requester bus and the synchronous SRAM port.
// slave: the bridge side; master: the requester plus memory side.
interface data_sram_like_resp_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addrok;
  logic        data_sram_dataok;
  logic [31:0] data_sram_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    input  data_sram_wstrb, data_sram_wdata, ram_rdata,
    output data_sram_addrok, data_sram_dataok, data_sram_rdata,
    output ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    output data_sram_wstrb, data_sram_wdata, ram_rdata,
    input  data_sram_addrok, data_sram_dataok, data_sram_rdata,
    input  ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/data_sram_like_resp.sv
// SRAM-like bus to synchronous SRAM bridge with a 2-deep in-order pending queue.
// dataok is registered: the head is retired one cycle before its response is shown.
module data_sram_like_resp #(
  parameter int unsigned RESP_DELAY = 0
) (
  input logic                  clk,
  input logic                  reset,
  data_sram_like_resp_if.slave bus
);
  localparam logic [3:0] Delay  = 4'(RESP_DELAY);
  localparam logic [3:0] AgeMax = 4'(RESP_DELAY + 1);

  logic [1:0]  count_q, count_d;
  logic        wr_q    [2];
  logic        wr_d    [2];
  logic        dv_q    [2];
  logic        dv_d    [2];
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [3:0]  age_q   [2];
  logic [3:0]  age_d   [2];
  logic        resp_q, resp_d;
  logic        resp_wr_q, resp_wr_d;
  logic        resp_byp_q, resp_byp_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        accept;
  logic        pop_head;

  always_comb begin
    bus.data_sram_addrok = !reset && (count_q < 2'd2);
    accept               = bus.data_sram_req && bus.data_sram_addrok;
    bus.ram_en           = accept;
    bus.ram_wen          = (accept && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'b0000;
    bus.ram_addr         = bus.data_sram_addr;
    bus.ram_wdata        = bus.data_sram_wdata;
    bus.data_sram_dataok = !reset && resp_q;
    bus.data_sram_rdata  = '0;
    if (bus.data_sram_dataok && !resp_wr_q) begin
      bus.data_sram_rdata = resp_byp_q ? bus.ram_rdata : resp_rdata_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_d[i]    = wr_q[i];
      dv_d[i]    = dv_q[i];
      rdata_d[i] = rdata_q[i];
      age_d[i]   = age_q[i];
      if (2'(i) < count_q) begin
        // SRAM data is only valid in the cycle after the access.
        if (!wr_q[i] && !dv_q[i] && age_q[i] == 4'd1) begin
          rdata_d[i] = bus.ram_rdata;
          dv_d[i]    = 1'b1;
        end
        if (age_q[i] < AgeMax) age_d[i] = age_q[i] + 4'd1;
      end
    end

    pop_head     = 1'b0;
    resp_d       = 1'b0;
    resp_wr_d    = 1'b0;
    resp_byp_d   = 1'b0;
    resp_rdata_d = '0;
    if (count_q != 2'd0) begin
      pop_head     = age_q[0] >= Delay;
      resp_d       = pop_head;
      resp_wr_d    = wr_q[0];
      resp_rdata_d = dv_q[0] ? rdata_q[0] : bus.ram_rdata;
    end else if (accept && Delay == 4'd0) begin
      // Zero delay: the new request never enters the queue, its data is bypassed.
      resp_d     = 1'b1;
      resp_wr_d  = bus.data_sram_wr;
      resp_byp_d = 1'b1;
    end

    count_d = count_q;
    if (pop_head) begin
      wr_d[0]    = wr_d[1];
      dv_d[0]    = dv_d[1];
      rdata_d[0] = rdata_d[1];
      age_d[0]   = age_d[1];
      count_d    = count_q - 2'd1;
    end
    if (accept && !resp_byp_d) begin
      wr_d[count_d[0]]    = bus.data_sram_wr;
      dv_d[count_d[0]]    = 1'b0;
      rdata_d[count_d[0]] = '0;
      age_d[count_d[0]]   = 4'd1;
      count_d             = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= 2'd0;
      resp_q       <= 1'b0;
      resp_wr_q    <= 1'b0;
      resp_byp_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_q[i]    <= 1'b0;
        dv_q[i]    <= 1'b0;
        rdata_q[i] <= '0;
        age_q[i]   <= 4'd0;
      end
    end else begin
      count_q      <= count_d;
      resp_q       <= resp_d;
      resp_wr_q    <= resp_wr_d;
      resp_byp_q   <= resp_byp_d;
      resp_rdata_q <= resp_rdata_d;
      for (int i = 0; i < 2; i++) begin
        wr_q[i]    <= wr_d[i];
        dv_q[i]    <= dv_d[i];
        rdata_q[i] <= rdata_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end
endmodule

// File: tb/tb_data_sram_like_resp.sv
// Three bridges (RESP_DELAY 0, 3, 5) share one stimulus; each lane has its own SRAM
// and a scoreboard deriving response cycles and data from acceptance times.
module tb_data_sram_like_resp;
  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'hDEADBEEF : {8'(i), 8'(~i), 8'(i * 3), 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  for (genvar l = 0; l < 3; l++) begin : g_lane
    localparam int D = (l == 0) ? 0 : (l == 1) ? 3 : 5;

    data_sram_like_resp_if bus ();

    data_sram_like_resp #(.RESP_DELAY(D)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
    );

    assign bus.data_sram_req   = req;
    assign bus.data_sram_wr    = wr;
    assign bus.data_sram_size  = size;
    assign bus.data_sram_addr  = addr;
    assign bus.data_sram_wstrb = wstrb;
    assign bus.data_sram_wdata = wdata;

    logic [31:0] mem    [256];
    logic [31:0] refmem [256];
    logic [31:0] ram_q;
    exp_t        pend [$];
    exp_t        e;
    int          last_due;
    int          cnt;

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    = init_word(i);
        refmem[i] = init_word(i);
      end
    end

    // Synchronous SRAM: read data appears the cycle after the access.
    always @(posedge clk) begin
      if (bus.ram_en) begin
        if (bus.ram_wen == 4'b0000) ram_q <= mem[bus.ram_addr[9:2]];
        else for (int b = 0; b < 4; b++)
          if (bus.ram_wen[b]) mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
    assign bus.ram_rdata = ram_q;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("L%0d rst addrok", l), 32'(bus.data_sram_addrok), 32'd0);
        chk($sformatf("L%0d rst dataok", l), 32'(bus.data_sram_dataok), 32'd0);
        chk($sformatf("L%0d rst rdata", l), bus.data_sram_rdata, 32'd0);
        chk($sformatf("L%0d rst ram_en", l), 32'(bus.ram_en), 32'd0);
        chk($sformatf("L%0d rst ram_wen", l), 32'(bus.ram_wen), 32'd0);
        pend.delete();
        last_due = 0;
      end else begin
        cnt = 0;
        foreach (pend[i]) if (pend[i].due > cyc) cnt++;
        chk($sformatf("L%0d addrok", l), 32'(bus.data_sram_addrok), 32'(cnt < 2));
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          chk($sformatf("L%0d dataok", l), 32'(bus.data_sram_dataok), 32'd1);
          chk($sformatf("L%0d rdata", l), bus.data_sram_rdata, pend[0].data);
          void'(pend.pop_front());
        end else begin
          chk($sformatf("L%0d idle dataok", l), 32'(bus.data_sram_dataok), 32'd0);
          chk($sformatf("L%0d idle rdata", l), bus.data_sram_rdata, 32'd0);
        end
        if (req && bus.data_sram_addrok) begin
          chk($sformatf("L%0d ram_en", l), 32'(bus.ram_en), 32'd1);
          chk($sformatf("L%0d ram_wen", l), 32'(bus.ram_wen), 32'(wr ? wstrb : 4'b0000));
          chk($sformatf("L%0d ram_addr", l), bus.ram_addr, addr);
          chk($sformatf("L%0d ram_wdata", l), bus.ram_wdata, wdata);
          e.due    = (cyc + 1 + D > last_due + 1) ? cyc + 1 + D : last_due + 1;
          last_due = e.due;
          e.wr     = wr;
          e.data   = wr ? 32'd0 : refmem[addr[9:2]];
          pend.push_back(e);
          if (wr) for (int b = 0; b < 4; b++)
            if (wstrb[b]) refmem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          chk($sformatf("L%0d no ram_en", l), 32'(bus.ram_en), 32'd0);
          chk($sformatf("L%0d no ram_wen", l), 32'(bus.ram_wen), 32'd0);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; req = q; wr = w; addr = a; wstrb = s; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  logic [31:0] w65;

  initial begin
    // Reset with a write request present: nothing may reach the SRAM.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 32'h100, 4'hF, 32'h12345678);
    idle(1);
    chk("addrok after reset L0", 32'(g_lane[0].bus.data_sram_addrok), 32'd1);
    chk("addrok after reset L2", 32'(g_lane[2].bus.data_sram_addrok), 32'd1);

    // Single read with zero delay: response in the very next cycle only.
    drive(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    chk("rd100 accept", 32'(g_lane[0].bus.ram_en), 32'd1);
    idle(1);
    chk("rd100 dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd1);
    chk("rd100 rdata", g_lane[0].bus.data_sram_rdata, 32'hDEADBEEF);
    idle(1);
    chk("rd100 single dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd0);
    idle(10);

    // Byte-1 write then read back the merged word.
    drive(1'b0, 1'b1, 1'b1, 32'h104, 4'b0010, 32'h0000AB00);
    chk("wr104 ram_wen", 32'(g_lane[0].bus.ram_wen), 32'h2);
    drive(1'b0, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
    chk("wr104 dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd1);
    chk("wr104 rdata zero", g_lane[0].bus.data_sram_rdata, 32'd0);
    idle(1);
    w65 = init_word(65);
    chk("rd104 dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd1);
    chk("rd104 rdata", g_lane[0].bus.data_sram_rdata, {w65[31:16], 8'hAB, w65[7:0]});
    idle(30);

    // Back-to-back reads with zero delay: full throughput.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
      chk("b2b addrok", 32'(g_lane[0].bus.data_sram_addrok), 32'd1);
      if (i > 0) chk("b2b dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd1);
    end
    idle(1);
    chk("b2b last dataok", 32'(g_lane[0].bus.data_sram_dataok), 32'd1);
    idle(30);

    // Delay 3: three reads presented from cycle 0.
    for (int i = 0; i < 10; i++) begin
      if (i < 5) drive(1'b0, 1'b1, 1'b0, 32'h108, 4'h0, 32'h0);
      else idle(1);
      if (i < 5) chk("d3 addrok", 32'(g_lane[1].bus.data_sram_addrok),
                     32'(i == 0 || i == 1 || i == 4));
      chk("d3 dataok", 32'(g_lane[1].bus.data_sram_dataok), 32'(i == 4 || i == 5 || i == 8));
    end
    idle(30);

    // Delay 5: reset while two reads are outstanding discards them.
    drive(1'b0, 1'b1, 1'b0, 32'h10C, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h110, 4'h0, 32'h0);
    chk("d5 second accept", 32'(g_lane[2].bus.ram_en), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h114, 4'h0, 32'h0);
    chk("d5 rst ram_en", 32'(g_lane[2].bus.ram_en), 32'd0);
    idle(1);
    chk("d5 addrok after reset", 32'(g_lane[2].bus.data_sram_addrok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("d5 no dataok", 32'(g_lane[2].bus.data_sram_dataok), 32'd0);
    end

    // Random read/write mix on a small address window so writes and reads collide.
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            {22'h0, 8'($urandom_range(0, 31)), 2'b00}, 4'($urandom), $urandom);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
